// File: rtl/prefix_merger_pkg.sv
// Shared encodings for the prefix merger stage:
// decoder ops, bundle kinds, error causes and the merged bundle layout.
package prefix_merger_pkg;

  typedef enum logic [2:0] {
    OP_D0   = 3'b000,
    OP_D1   = 3'b001,
    OP_W    = 3'b010,
    OP_T    = 3'b011,
    OP_I    = 3'b100,
    OP_FRAG = 3'b101,
    OP_BAD6 = 3'b110,
    OP_BAD7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    KIND_D      = 2'd0,
    KIND_W      = 2'd1,
    KIND_FSTART = 2'd2,
    KIND_FEND   = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ERR_DUP    = 2'd0,
    ERR_ORPHAN = 2'd1,
    ERR_BADOP  = 2'd2,
    ERR_NEST   = 2'd3
  } err_e;

  typedef enum logic {
    FS_OUT = 1'b0,
    FS_IN  = 1'b1
  } frag_st_e;

  typedef struct packed {
    kind_e       kind;
    logic [3:0]  funct;
    logic        immab;
    logic [31:0] imm;
    logic [23:0] ta;
    logic [7:0]  tt;
    logic [9:0]  offset;
    logic [5:0]  nalloc;
    logic        has_t;
    logic        has_i;
  } bundle_t;

  localparam int TA_LO_W = 12;
  localparam int TT_LO_W = 4;

  function automatic logic is_dw(op_e op);
    return (op == OP_D0) || (op == OP_D1) || (op == OP_W);
  endfunction

endpackage

// File: rtl/prefix_merger_imm_compose.sv
// Builds the 32-bit immediate: I-prefix high bits joined to the low
// field, or the low field sign-extended when no I prefix is held.
module imm_compose (
  input  logic        i_ipend,
  input  logic [25:0] i_immhi,
  input  logic [5:0]  i_immlo,
  output logic [31:0] o_imm
);

  assign o_imm = i_ipend ? {i_immhi, i_immlo}
                         : {{26{i_immlo[5]}}, i_immlo};

endmodule

// File: rtl/prefix_merger.sv
// Merges pending T/I prefixes into the next D/W word, forwards
// fragment markers and counts D/W words inside a fragment.
module prefix_merger
  import prefix_merger_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_funct,
  input  logic             in_immab,
  input  logic [5:0]       in_immlo,
  input  logic [25:0]      in_immhi,
  input  logic [23:0]      in_ta,
  input  logic [7:0]       in_tt,
  input  logic [9:0]       in_offset,
  input  logic [5:0]       in_nalloc,
  input  logic             in_endF,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [3:0]       out_funct,
  output logic             out_immab,
  output logic [31:0]      out_imm,
  output logic [23:0]      out_ta,
  output logic [7:0]       out_tt,
  output logic [9:0]       out_offset,
  output logic [5:0]       out_nalloc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_has_t,
  output logic             out_has_i,
  output logic             in_frag,
  output logic             err_pulse,
  output logic [1:0]       err_code
);

  bundle_t          r_out;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic             r_t_pend;
  logic             r_i_pend;
  logic [11:0]      r_ta_hi;
  logic [3:0]       r_tt_hi;
  logic [25:0]      r_immhi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_pulse;
  err_e             r_err_code;
  frag_st_e         r_st;

  op_e              w_op;
  logic             w_acc;
  logic             w_is_dw;
  logic             w_is_t;
  logic             w_is_i;
  logic             w_is_frag;
  logic [31:0]      w_imm;
  bundle_t          w_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_cnt_out;
  logic             w_err;
  err_e             w_code;
  logic             w_t_set;
  logic             w_i_set;
  logic             w_drop;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  frag_st_e         w_st_nxt;

  assign in_ready  = !r_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_op      = op_e'(in_op);
  assign w_is_dw   = is_dw(w_op);
  assign w_is_t    = (w_op == OP_T);
  assign w_is_i    = (w_op == OP_I);
  assign w_is_frag = (w_op == OP_FRAG);

  imm_compose u_imm (
    .i_ipend (r_i_pend),
    .i_immhi (r_immhi),
    .i_immlo (in_immlo),
    .o_imm   (w_imm)
  );

  always_ff @(posedge clk) begin
    if (rst) r_st <= FS_OUT;
    else     r_st <= w_st_nxt;
  end

  // Later assignments override earlier ones, giving NEST > BADOP > ORPHAN > DUP.
  always_comb begin
    w_nxt     = '0;
    w_load    = 1'b0;
    w_cnt_out = '0;
    w_err     = 1'b0;
    w_code    = ERR_DUP;
    w_t_set   = 1'b0;
    w_i_set   = 1'b0;
    w_drop    = 1'b0;
    w_cnt_inc = 1'b0;
    w_cnt_clr = 1'b0;
    w_st_nxt  = r_st;
    if (w_acc) begin
      unique case (1'b1)
        w_is_dw: begin
          w_load       = 1'b1;
          w_drop       = 1'b1;
          w_cnt_inc    = (r_st == FS_IN);
          w_nxt.kind   = (w_op == OP_W) ? KIND_W : KIND_D;
          w_nxt.funct  = in_funct;
          w_nxt.immab  = in_immab;
          w_nxt.imm    = w_imm;
          w_nxt.ta     = {r_t_pend ? r_ta_hi : 12'd0,
                          in_ta[TA_LO_W-1:0]};
          w_nxt.tt     = {r_t_pend ? r_tt_hi : 4'd0,
                          in_tt[TT_LO_W-1:0]};
          w_nxt.offset = in_offset;
          w_nxt.has_t  = r_t_pend;
          w_nxt.has_i  = r_i_pend;
        end
        w_is_t: begin
          w_t_set = 1'b1;
          w_err   = r_t_pend;
        end
        w_is_i: begin
          w_i_set = 1'b1;
          w_err   = r_i_pend;
        end
        w_is_frag: begin
          w_load    = 1'b1;
          w_drop    = 1'b1;
          w_cnt_clr = 1'b1;
          if (r_t_pend || r_i_pend) begin
            w_err  = 1'b1;
            w_code = ERR_ORPHAN;
          end
          if (in_endF) begin
            w_nxt.kind = KIND_FEND;
            w_st_nxt   = FS_OUT;
            if (r_st == FS_IN) begin
              w_cnt_out = r_cnt;
            end else begin
              w_err  = 1'b1;
              w_code = ERR_NEST;
            end
          end else begin
            w_nxt.kind   = KIND_FSTART;
            w_nxt.nalloc = in_nalloc;
            w_st_nxt     = FS_IN;
            if (r_st == FS_IN) begin
              w_err  = 1'b1;
              w_code = ERR_NEST;
            end
          end
        end
        default: begin
          w_drop = 1'b1;
          w_err  = 1'b1;
          w_code = ERR_BADOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_valid     <= 1'b0;
      r_count     <= '0;
      r_t_pend    <= 1'b0;
      r_i_pend    <= 1'b0;
      r_ta_hi     <= '0;
      r_tt_hi     <= '0;
      r_immhi     <= '0;
      r_cnt       <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_DUP;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) r_err_code <= w_code;
      if (w_load) begin
        r_out   <= w_nxt;
        r_count <= w_cnt_out;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_t_pend <= 1'b0;
        r_i_pend <= 1'b0;
      end
      if (w_t_set) begin
        r_t_pend <= 1'b1;
        r_ta_hi  <= in_ta[23:12];
        r_tt_hi  <= in_tt[7:4];
      end
      if (w_i_set) begin
        r_i_pend <= 1'b1;
        r_immhi  <= in_immhi;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_kind   = r_out.kind;
  assign out_funct  = r_out.funct;
  assign out_immab  = r_out.immab;
  assign out_imm    = r_out.imm;
  assign out_ta     = r_out.ta;
  assign out_tt     = r_out.tt;
  assign out_offset = r_out.offset;
  assign out_nalloc = r_out.nalloc;
  assign out_count  = r_count;
  assign out_has_t  = r_out.has_t;
  assign out_has_i  = r_out.has_i;
  assign in_frag    = (r_st == FS_IN);
  assign err_pulse  = r_err_pulse;
  assign err_code   = r_err_code;

endmodule
